// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit and the control unit.
// It holds the access size codes, the FSM state encoding, the byte-lane
// constants and the size/offset helper functions.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  // The control unit decodes func3 into these size codes.
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_BU = 3'b001;
  localparam logic [2:0] SZ_H  = 3'b010;
  localparam logic [2:0] SZ_HU = 3'b011;
  localparam logic [2:0] SZ_W  = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } lsu_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Codes 101-111 are not defined and behave as a word access.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    return (size > SZ_W) ? SZ_W : size;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_H, SZ_HU: mis = off[0];
      SZ_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Drops the low address bits below the natural alignment of the access.
  function automatic logic [1:0] align_offset(input logic [2:0] size, input logic [1:0] off);
    logic [1:0] res;
    case (size)
      SZ_H, SZ_HU: res = {off[1], 1'b0};
      SZ_W:        res = 2'b00;
      default:     res = off;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit_load_format.sv
// lsu_load_format: picks the addressed byte or half-word lane from a memory
// word and sign- or zero-extends it. Word accesses pass through unchanged.
// The size input is expected to be normalised already.
module lsu_load_format
  import load_store_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      size,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension.
  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   data = {24'h0, byte_sel};
      SZ_H:    data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage that sits after the control unit and the ALU.
// It issues word-aligned accesses to a data memory with synchronous read.
// Loads take two cycles. The read is issued in IDLE, and the data is
// formatted and written back in LOAD_WAIT.
// Stores complete in the cycle they are issued.
// Optional macro LSU_MISALIGN_TRAP_EN: a misaligned access is not issued,
// and misaligned pulses for one cycle. Without the macro, the low address
// bits are truncated.
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | accepts a new load or store
// ST_LOAD_WAIT | read data is valid; format it and return delayed_load/rd
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic            store_en,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            delayed_load,
  output logic [4:0]      delayed_rd,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  lsu_state_t      state;
  logic [2:0]      size_q;
  logic [1:0]      off_q;
  logic [2:0]      size_n;
  logic [1:0]      off_n;
  logic            mis;
  logic            issue_load;
  logic            issue_store;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] fmt_data;

  // Normalise the size and decide whether the access is misaligned.
  always_comb begin
    size_n = norm_size(size);
`ifdef LSU_MISALIGN_TRAP_EN
    mis   = is_misaligned(size_n, addr[1:0]);
    off_n = addr[1:0];
`else
    mis   = 1'b0;
    off_n = align_offset(size_n, addr[1:0]);
`endif
  end

  // Issue decision. A load takes priority over a store, and nothing is issued in LOAD_WAIT.
  always_comb begin
    issue_load  = (state == ST_IDLE) && load_en && !mis;
    issue_store = (state == ST_IDLE) && store_en && !load_en && !mis;
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_calc    = BE_WORD;
    dmem_wdata = store_data;
    case (size_n)
      SZ_B, SZ_BU: begin
        be_calc    = BE_BYTE0 << off_n;
        dmem_wdata = {4{store_data[7:0]}};
      end
      SZ_H, SZ_HU: begin
        be_calc    = off_n[1] ? BE_HALF_HI : BE_HALF_LO;
        dmem_wdata = {2{store_data[15:0]}};
      end
      default: begin
        be_calc    = BE_WORD;
        dmem_wdata = store_data;
      end
    endcase
  end

  assign dmem_addr = {addr[XLEN-1:2], 2'b00};
  assign dmem_re   = issue_load;
  assign dmem_we   = issue_store;
  assign dmem_be   = issue_store ? be_calc : BE_NONE;

  // Load FSM with registered write-back outputs.
`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      delayed_load <= 1'b0;
      delayed_rd   <= 5'd0;
      size_q       <= 3'b000;
      off_q        <= 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= (state == ST_IDLE) && (load_en || store_en) && mis;
`endif
      case (state)
        ST_IDLE: begin
          if (issue_load) begin
            state        <= ST_LOAD_WAIT;
            delayed_load <= 1'b1;
            delayed_rd   <= rd_in;
            size_q       <= size_n;
            off_q        <= off_n;
          end
        end
        default: begin
          state        <= ST_IDLE;
          delayed_load <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  lsu_load_format u_fmt (
    .rdata  (dmem_rdata),
    .size   (size_q),
    .offset (off_q),
    .data   (fmt_data)
  );

  assign load_data = (state == ST_LOAD_WAIT) ? fmt_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. It applies a table of directed vectors,
// then hand-written multi-cycle sequences, then random traffic that is
// checked against a byte-arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, store_en;
  logic [2:0]  size;
  logic [31:0] addr, store_data, dmem_rdata;
  logic [4:0]  rd_in;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic        dmem_re, dmem_we, delayed_load, misaligned;
  logic [3:0]  dmem_be;
  logic [4:0]  delayed_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .store_en     (store_en),
    .size         (size),
    .addr         (addr),
    .store_data   (store_data),
    .rd_in        (rd_in),
    .dmem_addr    (dmem_addr),
    .dmem_re      (dmem_re),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .delayed_load (delayed_load),
    .delayed_rd   (delayed_rd),
    .load_data    (load_data),
    .misaligned   (misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [2:0] sz);
    case (sz)
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit is_signed(input logic [2:0] sz);
    return (sz == 3'd0) || (sz == 3'd2);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [2:0] sz, input int off);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(sz);
    if (nb == 4) return rdata;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (rdata >> (8 * off)) & mask;
    if (is_signed(sz) && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] sz, input int off);
    logic [7:0] b;
    b = ((8'd1 << nbytes(sz)) - 8'd1) << off;
    return b[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] sd);
    case (nbytes(sz))
      1:       return {24'h0, sd[7:0]} * 32'h0101_0101;
      2:       return {16'h0, sd[15:0]} * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic        ld, st;
    logic [2:0]  sz;
    logic [31:0] a, sd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exp_re, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  vec_t vecs[13];

  // Random-phase model state
  bit          m_pend;
  logic [4:0]  m_rd;
  logic [2:0]  m_sz;
  int          m_off;
  bit          m_mis;

  initial begin
    vecs[0]  = '{"lb_0x103",   1, 0, 3'b000, 32'h103, 32'h0,        5'd5,  32'h80FF_1234, 1, 0, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{"lhu_0x202",  1, 0, 3'b011, 32'h202, 32'h0,        5'd6,  32'hBEEF_0000, 1, 0, 4'b0000, 32'h0,        32'h0000_BEEF};
    vecs[2]  = '{"lh_0x202",   1, 0, 3'b010, 32'h202, 32'h0,        5'd7,  32'hBEEF_0000, 1, 0, 4'b0000, 32'h0,        32'hFFFF_BEEF};
    vecs[3]  = '{"lbu_0x101",  1, 0, 3'b001, 32'h101, 32'h0,        5'd8,  32'h0000_8000, 1, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[4]  = '{"lw_0x400",   1, 0, 3'b100, 32'h400, 32'h0,        5'd31, 32'hDEAD_BEEF, 1, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[5]  = '{"lh_pos",     1, 0, 3'b010, 32'h200, 32'h0,        5'd1,  32'h1234_7FFF, 1, 0, 4'b0000, 32'h0,        32'h0000_7FFF};
    vecs[6]  = '{"sb_0x301",   0, 1, 3'b000, 32'h301, 32'h0000_00AB, 5'd0, 32'h0,         0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[7]  = '{"sh_0x102",   0, 1, 3'b010, 32'h102, 32'h1234_CAFE, 5'd0, 32'h0,         0, 1, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[8]  = '{"sw_0x010",   0, 1, 3'b100, 32'h010, 32'h0123_4567, 5'd0, 32'h0,         0, 1, 4'b1111, 32'h0123_4567, 32'h0};
    vecs[9]  = '{"ld_illegal", 1, 0, 3'b111, 32'h020, 32'h0,        5'd12, 32'h89AB_CDEF, 1, 0, 4'b0000, 32'h0,        32'h89AB_CDEF};
    vecs[10] = '{"ld_and_st",  1, 1, 3'b100, 32'h040, 32'h5555_5555, 5'd3, 32'h7654_3210, 1, 0, 4'b0000, 32'h0,        32'h7654_3210};
    vecs[11] = '{"sb_0x000",   0, 1, 3'b001, 32'h000, 32'h0000_005A, 5'd0, 32'h0,         0, 1, 4'b0001, 32'h5A5A_5A5A, 32'h0};
    vecs[12] = '{"st_illegal", 0, 1, 3'b101, 32'h008, 32'h1122_3344, 5'd0, 32'h0,         0, 1, 4'b1111, 32'h1122_3344, 32'h0};

    rst = 1'b0; load_en = 0; store_en = 0; size = 0; addr = 0;
    store_data = 0; rd_in = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_delayed_load", {31'd0, delayed_load}, 32'd0);
    check("reset_delayed_rd", {27'd0, delayed_rd}, 32'd0);
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
    check("reset_load_data", load_data, 32'd0);
    check("reset_no_re", {31'd0, dmem_re}, 32'd0);

    // Table vectors, each starting from IDLE
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      load_en = vecs[i].ld; store_en = vecs[i].st; size = vecs[i].sz;
      addr = vecs[i].a; store_data = vecs[i].sd; rd_in = vecs[i].rd;
      dmem_rdata = 32'hFFFF_FFFF;
      #1;
      check({vecs[i].name, "_re"}, {31'd0, dmem_re}, {31'd0, vecs[i].exp_re});
      check({vecs[i].name, "_we"}, {31'd0, dmem_we}, {31'd0, vecs[i].exp_we});
      check({vecs[i].name, "_be"}, {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
      check({vecs[i].name, "_addr"}, dmem_addr, {vecs[i].a[31:2], 2'b00});
      if (vecs[i].exp_we) check({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
      @(negedge clk);
      load_en = 0; store_en = 0; dmem_rdata = vecs[i].rdata;
      #1;
      check({vecs[i].name, "_dl"}, {31'd0, delayed_load}, {31'd0, vecs[i].exp_re});
      if (vecs[i].exp_re) begin
        check({vecs[i].name, "_rd"}, {27'd0, delayed_rd}, {27'd0, vecs[i].rd});
        check({vecs[i].name, "_data"}, load_data, vecs[i].exp_load);
        @(negedge clk);
        #1;
        check({vecs[i].name, "_idle_data"}, load_data, 32'd0);
      end
      @(negedge clk);
    end

    // Back-to-back LW with load_en held: re pattern 1,0,1,0
    begin
      int pulses;
      pulses = 0;
      load_en = 1; size = 3'b100; addr = 32'h80; rd_in = 5'd4;
      for (int c = 0; c < 4; c++) begin
        #1;
        check("b2b_re_cycle", {31'd0, dmem_re}, {31'd0, (c % 2) == 0});
        if (dmem_re) pulses++;
        @(negedge clk);
      end
      check("b2b_pulse_count", pulses, 2);
      load_en = 0;
      @(negedge clk);
    end

    // Reset during LOAD_WAIT
    load_en = 1; size = 3'b100; addr = 32'h44; rd_in = 5'd9;
    @(negedge clk);
    load_en = 0;
    #1;
    check("rstlw_pending", {31'd0, delayed_load}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstlw_dl", {31'd0, delayed_load}, 32'd0);
    check("rstlw_rd", {27'd0, delayed_rd}, 32'd0);
    rst = 1'b1; load_en = 1;
    #1;
    check("rstlw_idle_re", {31'd0, dmem_re}, 32'd1);
    @(negedge clk);
    load_en = 0;
    @(negedge clk);

    // LW at 0x402
    load_en = 1; size = 3'b100; addr = 32'h402; rd_in = 5'd10; dmem_rdata = 32'hCAFE_F00D;
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lw_re", {31'd0, dmem_re}, 32'd0);
    @(negedge clk);
    load_en = 0;
    #1;
    check("mis_lw_pulse", {31'd0, misaligned}, 32'd1);
    check("mis_lw_no_dl", {31'd0, delayed_load}, 32'd0);
    @(negedge clk);
    #1;
    check("mis_lw_pulse_end", {31'd0, misaligned}, 32'd0);
`else
    check("mis_lw_re", {31'd0, dmem_re}, 32'd1);
    check("mis_lw_addr", dmem_addr, 32'h400);
    @(negedge clk);
    load_en = 0;
    #1;
    check("mis_lw_data", load_data, 32'hCAFE_F00D);
    check("mis_lw_flag", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
`endif
    @(negedge clk);

    // Random traffic against the reference model (starts from IDLE)
    m_pend = 0; m_mis = 0; m_rd = 0; m_sz = 0; m_off = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit e_re, e_we, mis_hit, trap;
      int nb, aoff, off;
      rst        = ($urandom_range(0, 39) != 0);
      load_en    = ($urandom_range(0, 2) == 0);
      store_en   = ($urandom_range(0, 2) == 0);
      size       = 3'($urandom_range(0, 7));
      addr       = $urandom & 32'h0000_0FFF;
      store_data = $urandom;
      rd_in      = 5'($urandom);
      dmem_rdata = $urandom;
      nb   = nbytes(size);
      aoff = int'(addr[1:0]);
      mis_hit = (aoff % nb) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = mis_hit;
      off  = aoff;
`else
      trap = 0;
      off  = aoff - (aoff % nb);
`endif
      e_re = !m_pend && load_en && !trap;
      e_we = !m_pend && store_en && !load_en && !trap;
      #1;
      check("rnd_re", {31'd0, dmem_re}, {31'd0, e_re});
      check("rnd_we", {31'd0, dmem_we}, {31'd0, e_we});
      check("rnd_be", {28'd0, dmem_be}, e_we ? {28'd0, ref_be(size, off)} : 32'd0);
      check("rnd_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      if (e_we) check("rnd_wdata", dmem_wdata, ref_wdata(size, store_data));
      check("rnd_dl", {31'd0, delayed_load}, {31'd0, m_pend});
      check("rnd_load_data", load_data, m_pend ? ref_load(dmem_rdata, m_sz, m_off) : 32'd0);
      if (m_pend) check("rnd_rd", {27'd0, delayed_rd}, {27'd0, m_rd});
      check("rnd_mis", {31'd0, misaligned}, {31'd0, m_mis});
      if (!rst) begin
        m_pend = 0; m_mis = 0;
      end else if (m_pend) begin
        m_pend = 0; m_mis = 0;
      end else begin
        m_mis = trap && (load_en || store_en);
        if (e_re) begin
          m_pend = 1; m_rd = rd_in; m_sz = size; m_off = off;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
